// File: rtl/ibex_rvfi_trace_buffer.sv
// rtl/ibex_rvfi_trace_buffer.sv - RVFI retirement trace ring buffer with filter, overflow policy and PC trigger
// Entries are pushed on qualified retirements and drained first-word-fall-through.
module ibex_rvfi_trace_buffer #(
  parameter int Depth       = 16,
  parameter int PostTrigger = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rvfi_valid_i,
  input  logic [63:0]                rvfi_order_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic                       rvfi_trap_i,
  input  logic                       rvfi_intr_i,
  input  logic                       rvfi_halt_i,
  input  logic [1:0]                 rvfi_mode_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_pc_wdata_i,
  input  logic [1:0]                 cfg_mode_i,
  input  logic                       cfg_wrap_i,
  input  logic                       cfg_clear_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [31:0]                rd_pc_o,
  output logic [31:0]                rd_insn_o,
  output logic [15:0]                rd_order_o,
  output logic [4:0]                 rd_flags_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic [15:0]                dropped_o,
  output logic                       frozen_o,
  output logic                       trig_hit_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {ARMED, POST, FROZEN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   post_q, post_d;
  logic            hit_q, hit_d;

  logic [31:0]     pc_mem    [Depth];
  logic [31:0]     insn_mem  [Depth];
  logic [15:0]     order_mem [Depth];
  logic [4:0]      flag_mem  [Depth];

  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;
  logic [15:0]     dropped_q;

  logic [31:0]     step;
  logic            discont, filt, q, full, empty, pop, write, drop, adv_rd;
  logic            unused_order;

  assign unused_order = ^rvfi_order_i[63:16];

  always_comb begin
    step    = (rvfi_insn_i[1:0] == 2'b11) ? 32'd4 : 32'd2;
    discont = rvfi_pc_wdata_i != (rvfi_pc_rdata_i + step);
    case (cfg_mode_i)
      2'd1:    filt = 1'b1;
      2'd2:    filt = rvfi_trap_i | rvfi_intr_i;
      2'd3:    filt = rvfi_trap_i | rvfi_intr_i | discont;
      default: filt = 1'b0;
    endcase
    q      = rvfi_valid_i && filt && (state_q != FROZEN);
    full   = level_q == LW'(Depth);
    empty  = level_q == '0;
    pop    = !empty && rd_ready_i;
    // When full without a pop, wrap mode overwrites the head slot (wptr == rptr).
    write  = q && (!full || pop || cfg_wrap_i);
    drop   = q && full && !pop;
    adv_rd = pop || (drop && cfg_wrap_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      dropped_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        pc_mem[i]    <= '0;
        insn_mem[i]  <= '0;
        order_mem[i] <= '0;
        flag_mem[i]  <= '0;
      end
    end else if (cfg_clear_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      dropped_q <= '0;
    end else begin
      if (write) begin
        pc_mem[wptr_q]    <= rvfi_pc_rdata_i;
        insn_mem[wptr_q]  <= rvfi_insn_i;
        order_mem[wptr_q] <= rvfi_order_i[15:0];
        flag_mem[wptr_q]  <= {rvfi_mode_i, rvfi_halt_i, rvfi_intr_i, rvfi_trap_i};
        wptr_q            <= wptr_q + AW'(1);
      end
      if (adv_rd) rptr_q <= rptr_q + AW'(1);
      if (write && !full && !pop) level_q <= level_q + LW'(1);
      else if (pop && !write)     level_q <= level_q - LW'(1);
      if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    hit_d   = 1'b0;
    if (cfg_clear_i) begin
      state_d = ARMED;
      post_d  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (q && trig_en_i && (rvfi_pc_rdata_i == trig_pc_i)) begin
            hit_d = 1'b1;
            if (PostTrigger == 0) begin
              state_d = FROZEN;
            end else begin
              state_d = POST;
              post_d  = AW'(PostTrigger);
            end
          end
        end
        POST: begin
          if (q) begin
            post_d = post_q - AW'(1);
            if (post_q == AW'(1)) state_d = FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARMED;
      post_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      hit_q   <= hit_d;
    end
  end

  assign rd_valid_o = !empty;
  assign rd_pc_o    = pc_mem[rptr_q];
  assign rd_insn_o  = insn_mem[rptr_q];
  assign rd_order_o = order_mem[rptr_q];
  assign rd_flags_o = flag_mem[rptr_q];
  assign level_o    = level_q;
  assign dropped_o  = dropped_q;
  assign frozen_o   = state_q == FROZEN;
  assign trig_hit_o = hit_q;

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
# ibex_rvfi_trace_buffer

Synthesizable on-chip trace capture for the Ibex core. It samples the core's RVFI retirement stream into a parametrised ring buffer, with selectable filter modes, overflow policy, and a PC-match trigger with post-trigger depth. Stored entries drain through a valid/ready read port. It sits beside `ibex_top` in traced builds and replaces the simulation-only text tracer wherever silicon-visible trace is needed.

## Interface
Parameters:
- `Depth`, 16: number of entries; power of two, minimum 2.
- `PostTrigger`, 4: qualified entries captured after the trigger entry before freezing; 0 to `Depth-1`.

Ports:
- `clk_i` in 1: core clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `rvfi_valid_i` in 1: retirement strobe.
- `rvfi_order_i` in 64: retirement order; bits [15:0] are stored.
- `rvfi_insn_i` in 32: retired instruction.
- `rvfi_trap_i`, `rvfi_intr_i`, `rvfi_halt_i` in 1 each: retirement flags.
- `rvfi_mode_i` in 2: privilege mode.
- `rvfi_pc_rdata_i` in 32: PC of the retired instruction.
- `rvfi_pc_wdata_i` in 32: next PC.
- `cfg_mode_i` in 2: capture filter. 0 = off, 1 = all retirements, 2 = trap/intr only, 3 = control-flow discontinuities.
- `cfg_wrap_i` in 1: 1 = overwrite oldest when full; 0 = discard new when full.
- `cfg_clear_i` in 1: synchronous clear pulse.
- `trig_en_i` in 1: enable PC-match trigger.
- `trig_pc_i` in 32: trigger PC.
- `rd_ready_i` in 1: consumer accepts head entry.
- `rd_valid_o` out 1: head entry valid.
- `rd_pc_o` out 32: head `pc_rdata`.
- `rd_insn_o` out 32: head `insn`.
- `rd_order_o` out 16: head order[15:0].
- `rd_flags_o` out 5: head {mode[1:0], halt, intr, trap}.
- `level_o` out $clog2(Depth)+1: stored entry count.
- `dropped_o` out 16: lost-entry count, saturating at 16'hFFFF.
- `frozen_o` out 1: capture stopped by trigger.
- `trig_hit_o` out 1: one-cycle pulse when the trigger entry is captured.

## Operation
- Qualification (`q`) requires `rvfi_valid_i`, `cfg_mode_i != 0`, and state not FROZEN.
  - Mode 1: every retirement qualifies.
  - Mode 2: qualifies if trap or intr.
  - Mode 3: qualifies if trap or intr, or if `pc_wdata != pc_rdata + step`. `step` is 4 when `insn[1:0]==2'b11`, otherwise 2. The addition is 32-bit modulo.
- FSM states:
  - ARMED (reset state): every `q` entry is pushed. If `trig_en_i` is high and `pc_rdata == trig_pc_i` on a `q` entry, that entry is pushed and `trig_hit_o` pulses. The FSM then goes to POST with `post_cnt = PostTrigger`, or straight to FROZEN if `PostTrigger == 0`.
  - POST: each `q` entry is pushed and decrements `post_cnt`; the push that takes it from 1 to 0 moves the FSM to FROZEN. Trigger matches are ignored in POST.
  - FROZEN: no pushes, and `dropped_o` is not incremented. Reads continue. `frozen_o` is 1.
- `cfg_clear_i` has priority over push, pop, and trigger. It empties the buffer (pointers and level), zeroes `dropped_o`, and returns the FSM to ARMED.
- Read port is first-word-fall-through. `rd_valid_o = (level != 0)` and the `rd_*` outputs show the head entry. A pop happens when `rd_valid_o && rd_ready_i`.
- Full buffer (`level == Depth`) with a push and no pop:
  - `cfg_wrap_i = 1`: the oldest entry is overwritten, the head advances, level stays at `Depth`, and `dropped_o` increments.
  - `cfg_wrap_i = 0`: the new entry is discarded and `dropped_o` increments.
- Full buffer with push and pop in the same cycle: both happen, level is unchanged, no drop.
- Empty buffer with push and pop in the same cycle: the pop is not possible (`rd_valid_o = 0`); only the push takes effect.
- Pointers wrap modulo `Depth`.

## Timing
- Latency: an entry sampled with `rvfi_valid_i` on edge N appears on the `rd_*` outputs and in `level_o` after edge N (one cycle).
- A pop on edge N takes effect after edge N; the next entry is presented in the same cycle.
- FSM transitions, `frozen_o` and `trig_hit_o` are registered and change after the sampling edge.
- Reset values:
  - `rd_valid_o` = 0, `level_o` = 0, `dropped_o` = 0, `frozen_o` = 0, `trig_hit_o` = 0.
  - All `rd_*` data outputs are 0; storage is reset to 0.
  - State is ARMED.
- A reset asserted mid-capture or mid-read discards all contents immediately (asynchronous).
- `cfg_*` and `trig_*` inputs are sampled every cycle; a change takes effect on the next retirement.

## Test plan
- Fill, then drain: mode 1, `Depth = 16`, 16 retirements at PC 0x100, 0x104, … → `level_o = 16`, `dropped_o = 0`; draining with `rd_ready_i = 1` returns the PCs in order 0x100…0x13C.
- Overflow with wrap: `cfg_wrap_i = 1`, 20 retirements, no reads → `level_o = 16`, `dropped_o = 4`, first entry read has PC 0x110. Repeat with `cfg_wrap_i = 0` → first entry read has PC 0x100, `dropped_o = 4`.
- Discontinuity filter: mode 3 with the following retirements → exactly entries 2, 3, 4 are captured, with `rd_flags_o` trap = 1 on the third.
  - 32-bit insn at 0x200 → 0x204
  - 16-bit insn at 0x204 → 0x300
  - 32-bit insn at 0x300 → 0x304 with `rvfi_intr_i = 1`
  - trap at 0x304 → 0x1A110808
- Trigger: `PostTrigger = 4`, `trig_pc_i = 0x400`, retire PCs 0x3F8…0x420 → `trig_hit_o` pulses once after the 0x400 entry. After 0x410, `frozen_o = 1`. Stored set ends at 0x410 and later retirements do not change `dropped_o`.
- Simultaneous events:
  - Full buffer with push and pop on one edge → level stays at 16, `dropped_o` unchanged.
  - `cfg_clear_i` together with push and pop → `level_o = 0`, ARMED.
- Async reset asserted while `level_o = 7` and FROZEN → all outputs 0 immediately. The first retirement after reset is captured with `level_o = 1`.
